// File: rtl/soc_addr_router_pkg.sv
// SoC address map, slave encoding and response codes shared by all map consumers.
package soc_addr_router_pkg;

    localparam int unsigned NB_PERIPHERALS = 8;

    typedef logic [$clog2(NB_PERIPHERALS)-1:0] slv_idx_t;

    typedef enum logic [2:0] {
        DRAM     = 3'd0,
        ETHERNET = 3'd1,
        SPI      = 3'd2,
        UART     = 3'd3,
        PLIC     = 3'd4,
        CLINT    = 3'd5,
        ROM      = 3'd6,
        DEBUG    = 3'd7
    } axi_slaves_t;

    localparam logic [63:0] DebugBase    = 64'h0000_0000;
    localparam logic [63:0] DebugLength  = 64'h0000_1000;
    localparam logic [63:0] ROMBase      = 64'h0001_0000;
    localparam logic [63:0] ROMLength    = 64'h0001_0000;
    localparam logic [63:0] CLINTBase    = 64'h0200_0000;
    localparam logic [63:0] CLINTLength  = 64'h000C_0000;
    localparam logic [63:0] PLICBase     = 64'h0C00_0000;
    localparam logic [63:0] PLICLength   = 64'h0400_0000;
    localparam logic [63:0] UARTBase     = 64'h1000_0000;
    localparam logic [63:0] UARTLength   = 64'h0000_1000;
    localparam logic [63:0] SPIBase      = 64'h2000_0000;
    localparam logic [63:0] SPILength    = 64'h0080_0000;
    localparam logic [63:0] EthernetBase = 64'h3000_0000;
    localparam logic [63:0] EthernetLength = 64'h0001_0000;
    localparam logic [63:0] DRAMBase     = 64'h8000_0000;
    localparam logic [63:0] DRAMLength   = 64'h0800_0000;

    typedef struct packed {
        slv_idx_t    idx;
        logic [63:0] base;
        logic [63:0] length;
    } addr_rule_t;

    localparam addr_rule_t ADDR_MAP [NB_PERIPHERALS] = '{
        '{idx: slv_idx_t'(DRAM),     base: DRAMBase,     length: DRAMLength},
        '{idx: slv_idx_t'(ETHERNET), base: EthernetBase, length: EthernetLength},
        '{idx: slv_idx_t'(SPI),      base: SPIBase,      length: SPILength},
        '{idx: slv_idx_t'(UART),     base: UARTBase,     length: UARTLength},
        '{idx: slv_idx_t'(PLIC),     base: PLICBase,     length: PLICLength},
        '{idx: slv_idx_t'(CLINT),    base: CLINTBase,    length: CLINTLength},
        '{idx: slv_idx_t'(ROM),      base: ROMBase,      length: ROMLength},
        '{idx: slv_idx_t'(DEBUG),    base: DebugBase,    length: DebugLength}
    };

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_ERR
    } router_state_e;

endpackage

// File: rtl/soc_addr_router_if.sv
// Request, forward and error-response signals of the address router.
interface soc_addr_router_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned LenWidth  = 8,
    parameter int unsigned CntWidth  = 16
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic [IdWidth-1:0]   req_id_i;
    logic [LenWidth-1:0]  req_len_i;
    logic                 req_we_i;

    logic                 slv_valid_o;
    logic                 slv_ready_i;
    logic [2:0]           slv_sel_o;
    logic [AddrWidth-1:0] slv_addr_o;
    logic [IdWidth-1:0]   slv_id_o;
    logic [LenWidth-1:0]  slv_len_o;
    logic                 slv_we_o;

    logic                 err_valid_o;
    logic                 err_ready_i;
    logic [IdWidth-1:0]   err_id_o;
    logic                 err_we_o;
    logic                 err_last_o;
    logic [1:0]           err_resp_o;
    logic [CntWidth-1:0]  err_cnt_o;

    // Router side.
    modport slave (
        input  req_valid_i, req_addr_i, req_id_i, req_len_i, req_we_i,
        input  slv_ready_i, err_ready_i,
        output req_ready_o,
        output slv_valid_o, slv_sel_o, slv_addr_o, slv_id_o, slv_len_o, slv_we_o,
        output err_valid_o, err_id_o, err_we_o, err_last_o, err_resp_o, err_cnt_o
    );

    // Core / crossbar side.
    modport master (
        output req_valid_i, req_addr_i, req_id_i, req_len_i, req_we_i,
        output slv_ready_i, err_ready_i,
        input  req_ready_o,
        input  slv_valid_o, slv_sel_o, slv_addr_o, slv_id_o, slv_len_o, slv_we_o,
        input  err_valid_o, err_id_o, err_we_o, err_last_o, err_resp_o, err_cnt_o
    );
endinterface

// File: rtl/soc_addr_router_decode.sv
// Combinational address-map decoder; lowest rule index wins on overlap.
module soc_addr_decode
    import soc_addr_router_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] i_addr,
    output logic                 o_hit,
    output slv_idx_t             o_idx
);

    logic [AddrWidth:0] w_base;
    logic [AddrWidth:0] w_end;
    logic [AddrWidth:0] w_addr;

    // Scan the rule table; end address computed one bit wider so it cannot wrap.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        w_base = '0;
        w_end  = '0;
        w_addr = {1'b0, i_addr};
        for (int unsigned i = 0; i < NB_PERIPHERALS; i++) begin
            w_base = {1'b0, ADDR_MAP[i].base[AddrWidth-1:0]};
            w_end  = w_base + {1'b0, ADDR_MAP[i].length[AddrWidth-1:0]};
            if (!o_hit && (w_addr >= w_base) && (w_addr < w_end)) begin
                o_hit = 1'b1;
                o_idx = ADDR_MAP[i].idx;
            end
        end
    end

endmodule

// File: rtl/soc_addr_router.sv
// Single-slot request router: forwards map hits, answers misses with DECERR beats.
module soc_addr_router
    import soc_addr_router_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned LenWidth  = 8,
    parameter int unsigned CntWidth  = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    soc_addr_router_if.slave   bus
);

    router_state_e        r_state;
    router_state_e        w_state_nxt;
    logic [AddrWidth-1:0] r_addr;
    logic [IdWidth-1:0]   r_id;
    logic [LenWidth-1:0]  r_len;
    logic                 r_we;
    slv_idx_t             r_sel;
    logic [LenWidth-1:0]  r_beat;
    logic [CntWidth-1:0]  r_err_cnt;

    logic                 w_hit;
    slv_idx_t             w_idx;
    logic                 w_accept;
    logic                 w_last;

    soc_addr_decode #(
        .AddrWidth (AddrWidth)
    ) u_decode (
        .i_addr (bus.req_addr_i),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_last          = (r_beat == '0);
        bus.req_ready_o = 1'b0;
        bus.slv_valid_o = 1'b0;
        bus.err_valid_o = 1'b0;
        bus.err_last_o  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_hit ? ST_FWD : ST_ERR;
                end
            end
            ST_FWD: begin
                bus.slv_valid_o = 1'b1;
                if (bus.slv_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                bus.err_valid_o = 1'b1;
                bus.err_last_o  = w_last;
                if (bus.err_ready_i && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Payload capture, DECERR beat counter and saturating miss counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_beat    <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= bus.req_addr_i;
                r_id   <= bus.req_id_i;
                r_len  <= bus.req_len_i;
                r_we   <= bus.req_we_i;
                r_sel  <= w_idx;
                if (!w_hit) begin
                    // Writes get a single B beat; reads get len+1 R beats.
                    r_beat <= bus.req_we_i ? '0 : bus.req_len_i;
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + CntWidth'(1);
                    end
                end
            end else if (r_state == ST_ERR && bus.err_ready_i && !w_last) begin
                r_beat <= r_beat - LenWidth'(1);
            end
        end
    end

    assign bus.slv_sel_o  = r_sel;
    assign bus.slv_addr_o = r_addr;
    assign bus.slv_id_o   = r_id;
    assign bus.slv_len_o  = r_len;
    assign bus.slv_we_o   = r_we;
    assign bus.err_id_o   = r_id;
    assign bus.err_we_o   = r_we;
    assign bus.err_resp_o = RESP_DECERR;
    assign bus.err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_soc_addr_router.sv
// Directed bench for soc_addr_router with a scoreboard of expected output beats.
module tb_soc_addr_router;

    localparam int unsigned CNT_W = 10;

    typedef struct {
        bit          is_err;
        logic [2:0]  sel;
        logic [63:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic        we;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [CNT_W-1:0] exp_cnt = '0;

    soc_addr_router_if #(
        .AddrWidth (64),
        .IdWidth   (4),
        .LenWidth  (8),
        .CntWidth  (CNT_W)
    ) bus ();

    soc_addr_router #(
        .AddrWidth (64),
        .IdWidth   (4),
        .LenWidth  (8),
        .CntWidth  (CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference address map, written out as explicit ranges.
    function automatic void model_decode(input logic [63:0] a, output bit hit, output logic [2:0] sel);
        hit = 1'b1;
        sel = 3'd0;
        if (a < 64'h0000_1000)                                 sel = 3'd7;
        else if (a >= 64'h0001_0000 && a < 64'h0002_0000)      sel = 3'd6;
        else if (a >= 64'h0200_0000 && a < 64'h020C_0000)      sel = 3'd5;
        else if (a >= 64'h0C00_0000 && a < 64'h1000_0000)      sel = 3'd4;
        else if (a >= 64'h1000_0000 && a < 64'h1000_1000)      sel = 3'd3;
        else if (a >= 64'h2000_0000 && a < 64'h2080_0000)      sel = 3'd2;
        else if (a >= 64'h3000_0000 && a < 64'h3001_0000)      sel = 3'd1;
        else if (a >= 64'h8000_0000 && a < 64'h8800_0000)      sel = 3'd0;
        else hit = 1'b0;
    endfunction

    // Output monitor: every handshake pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.slv_valid_o || bus.err_valid_o)
                chk("valid_excl", 64'(bus.slv_valid_o & bus.err_valid_o), 64'd0);
            if (bus.slv_valid_o && bus.slv_ready_i) begin
                chk("fwd_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("fwd_kind", 64'(mon_e.is_err), 64'd0);
                    chk("slv_sel",  64'(bus.slv_sel_o),  64'(mon_e.sel));
                    chk("slv_addr", bus.slv_addr_o,      mon_e.addr);
                    chk("slv_id",   64'(bus.slv_id_o),   64'(mon_e.id));
                    chk("slv_len",  64'(bus.slv_len_o),  64'(mon_e.len));
                    chk("slv_we",   64'(bus.slv_we_o),   64'(mon_e.we));
                end
            end
            if (bus.err_valid_o && bus.err_ready_i) begin
                chk("err_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("err_kind", 64'(mon_e.is_err),   64'd1);
                    chk("err_id",   64'(bus.err_id_o),   64'(mon_e.id));
                    chk("err_we",   64'(bus.err_we_o),   64'(mon_e.we));
                    chk("err_last", 64'(bus.err_last_o), 64'(mon_e.last));
                    chk("err_resp", 64'(bus.err_resp_o), 64'd3);
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [3:0] id, input logic [7:0] len, input logic we);
        bit          hit;
        logic [2:0]  sel;
        exp_t        e;
        int unsigned beats;
        int unsigned waited;
        model_decode(a, hit, sel);
        e.sel = sel; e.addr = a; e.id = id; e.len = len; e.we = we;
        if (hit) begin
            e.is_err = 1'b0; e.last = 1'b0;
            sb.push_back(e);
        end else begin
            if (exp_cnt != '1) exp_cnt++;
            beats = we ? 1 : int'(len) + 1;
            for (int unsigned b = 0; b < beats; b++) begin
                e.is_err = 1'b1;
                e.last   = (b == beats - 1);
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_id_i    = id;
        bus.req_len_i   = len;
        bus.req_we_i    = we;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready_o && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", 64'(waited < 1000), 64'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk(hit ? "fwd_latency" : "err_latency",
            64'(hit ? bus.slv_valid_o : bus.err_valid_o), 64'd1);
        chk("err_cnt", 64'(bus.err_cnt_o), 64'(exp_cnt));
    endtask

    task automatic drain(input bit rnd);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            if (rnd) bus.err_ready_i = 1'($urandom_range(0, 1));
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        bus.err_ready_i = 1'b1;
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_id_i    = '0;
        bus.req_len_i   = '0;
        bus.req_we_i    = 1'b0;
        bus.slv_ready_i = 1'b1;
        bus.err_ready_i = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #19;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_slv_valid", 64'(bus.slv_valid_o), 64'd0);
        chk("rst_err_valid", 64'(bus.err_valid_o), 64'd0);
        chk("rst_err_last",  64'(bus.err_last_o),  64'd0);
        chk("rst_err_cnt",   64'(bus.err_cnt_o),   64'd0);
        chk("rst_slv_addr",  bus.slv_addr_o,       64'd0);
        #2 rst_n = 1'b1;

        // UART hit at its last byte, then the first byte past it.
        send(64'h1000_0FFF, 4'd1, 8'd0, 1'b0); drain(1'b0);
        send(64'h1000_1000, 4'd2, 8'd0, 1'b0); drain(1'b0);

        // Map edges.
        send(64'h87FF_FFFF, 4'd3, 8'd1, 1'b0); drain(1'b0);
        send(64'h8800_0000, 4'd4, 8'd0, 1'b1); drain(1'b0);
        send(64'h0000_0FFF, 4'd5, 8'd0, 1'b0); drain(1'b0);
        send(64'h0000_1000, 4'd6, 8'd0, 1'b1); drain(1'b0);
        send(64'h0C00_0000, 4'd7, 8'd2, 1'b1); drain(1'b0);

        // Write miss: one B beat regardless of len; long read miss: 256 R beats.
        send(64'h4000_0000, 4'd5, 8'd7, 1'b1);   drain(1'b0);
        send(64'h4000_0000, 4'd8, 8'd255, 1'b0); drain(1'b0);

        // Forward backpressure.
        bus.slv_ready_i = 1'b0;
        send(64'h8000_1234, 4'd9, 8'd4, 1'b1);
        for (int unsigned c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.slv_valid_o), 64'd1);
            chk("bp_ready", 64'(bus.req_ready_o), 64'd0);
            chk("bp_addr",  bus.slv_addr_o,       64'h8000_1234);
            chk("bp_id",    64'(bus.slv_id_o),    64'd9);
            chk("bp_len",   64'(bus.slv_len_o),   64'd4);
            chk("bp_sel",   64'(bus.slv_sel_o),   64'd0);
        end
        @(posedge clk); #1 bus.slv_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", 64'(bus.req_ready_o), 64'd1);
        chk("bp_release_valid", 64'(bus.slv_valid_o), 64'd0);
        chk("bp_drained",       64'(sb.size()),       64'd0);

        // Randomly throttled error beats.
        bus.err_ready_i = 1'b0;
        send(64'h6000_0000, 4'd6, 8'd3, 1'b0);
        drain(1'b1);

        // Reset in the middle of an error burst.
        bus.err_ready_i = 1'b0;
        send(64'h5000_0000, 4'd2, 8'd3, 1'b0);
        @(posedge clk); #1 bus.err_ready_i = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 bus.err_ready_i = 1'b0;
        chk("beats_before_rst", 64'(sb.size()), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_err_valid", 64'(bus.err_valid_o), 64'd0);
        chk("rst_mid_err_cnt",   64'(bus.err_cnt_o),   64'd0);
        chk("rst_mid_req_ready", 64'(bus.req_ready_o), 64'd1);
        sb.delete();
        exp_cnt = '0;
        bus.err_ready_i = 1'b1;
        #20 rst_n = 1'b1;
        send(64'h0200_0000, 4'd3, 8'd0, 1'b0); drain(1'b0);

        // Miss counter saturation, then one more miss.
        while (exp_cnt != '1) begin
            send(64'h4000_0000, 4'd1, 8'd0, 1'b1);
            drain(1'b0);
        end
        send(64'h4000_0000, 4'd1, 8'd0, 1'b1); drain(1'b0);
        chk("cnt_saturated", 64'(bus.err_cnt_o), 64'((1 << CNT_W) - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
